// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, the per-axis phase type and its decode helper.
package vga_timing_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

  // Boundaries are the first count of FRONT, SYNC and BACK respectively.
  function automatic phase_e axis_phase(input logic [CNT_W-1:0] c,
                                        input logic [CNT_W-1:0] fp_start,
                                        input logic [CNT_W-1:0] sync_start,
                                        input logic [CNT_W-1:0] bp_start);
    if (c < fp_start)   return PH_ACTIVE;
    if (c < sync_start) return PH_FRONT;
    if (c < bp_start)   return PH_SYNC;
    return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus look-ahead of its next value and phase,
// so the top can register outputs that line up with the counter.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_D,
  parameter int FP     = H_FP_D,
  parameter int SYNC   = H_SYNC_D,
  parameter int BP     = H_BP_D
) (
  input  logic             clkglobal,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_next,
  output phase_e           phase_next,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    cnt_next   = cnt_d;
    phase_next = axis_phase(cnt_d, FP_START, SYNC_START, BP_START);
  end

  // Parked on the last count so the first enable after reset lands on 0.
  always_ff @(posedge clkglobal or negedge reset) begin
    if (!reset) cnt_q <= LAST;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: two axis counters and registered sync/video/coordinate
// outputs loaded from the counters' next values on each pixel enable.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clkglobal,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_tick,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] h_cnt_next, v_cnt_next;
  phase_e           h_phase_next, v_phase_next;
  logic             h_wrap, v_wrap, v_en;

  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clkglobal (clkglobal),
    .reset     (reset),
    .en        (pix_en),
    .cnt_next  (h_cnt_next),
    .phase_next(h_phase_next),
    .wrap      (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clkglobal (clkglobal),
    .reset     (reset),
    .en        (v_en),
    .cnt_next  (v_cnt_next),
    .phase_next(v_phase_next),
    .wrap      (v_wrap)
  );

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
  logic [CNT_W-1:0] pixel_y_q, pixel_y_d;
  logic             line_tick_q, line_tick_d;
  logic             frame_tick_q, frame_tick_d;

  always_comb begin
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    video_on_d   = video_on_q;
    pixel_x_d    = pixel_x_q;
    pixel_y_d    = pixel_y_q;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    if (pix_en) begin
      hsync_d      = (h_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d      = (v_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on_d   = (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
      pixel_x_d    = h_cnt_next;
      pixel_y_d    = v_cnt_next;
      line_tick_d  = h_wrap;
      frame_tick_d = h_wrap & v_wrap;
    end
  end

  always_ff @(posedge clkglobal or negedge reset) begin
    if (!reset) begin
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      video_on_q   <= 1'b0;
      pixel_x_q    <= H_LAST;
      pixel_y_q    <= V_LAST;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      pixel_x_q    <= pixel_x_d;
      pixel_y_q    <= pixel_y_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates the 640x480@60 Hz VGA raster from the 50 MHz system clock and a 25 MHz pixel-enable, which is the registered half-rate toggle from the clock divider. Produces hsync, vsync, the active-video flag and the current pixel coordinates for the pixel/colour stage downstream. The block runs entirely on `clkglobal`. It advances only on cycles where `pix_en` is high.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clkglobal  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel-enable, high one cycle in two
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- video_on  out  1  high while (pixel_x, pixel_y) is inside the visible area
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- line_tick  out  1  one-clkglobal pulse when pixel_x wraps to 0
- frame_tick  out  1  one-clkglobal pulse when (pixel_x, pixel_y) becomes (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024.
- Horizontal counter h:
  - increments on each clkglobal edge with pix_en=1;
  - wraps from H_TOTAL-1 to 0.
- Vertical counter v:
  - increments only on a pix_en edge where h wraps;
  - wraps from V_TOTAL-1 to 0.
- Per-axis phase, decoded from the counter:
  - ACTIVE: [0, ACTIVE-1]
  - FRONT: [ACTIVE, ACTIVE+FP-1]
  - SYNC: [ACTIVE+FP, ACTIVE+FP+SYNC-1] (h 656..751, v 490..491)
  - BACK: the remainder
- All outputs are registered.
  - On a pix_en edge they are loaded from the decode of the next counter values, so pixel_x/pixel_y and the flags always describe the same pixel.
- Output decode:
  - hsync = SYNC_POL while h is in SYNC, else ~SYNC_POL; vsync likewise from v.
  - video_on = (h in ACTIVE) && (v in ACTIVE).
- pix_en=0: counters and hsync/vsync/video_on/pixel_x/pixel_y hold; line_tick/frame_tick return to 0.
- Reset (asynchronous, any time, including mid-line or mid-frame):
  - h = 799, v = 524;
  - hsync = vsync = ~SYNC_POL, video_on = 0;
  - pixel_x = 799, pixel_y = 524;
  - line_tick = frame_tick = 0.
  - The first pix_en after reset release therefore enters (0,0), with video_on=1 and both ticks pulsing.

## Timing
- Pixel latency: 0. Outputs change on the same clkglobal edge that sees pix_en=1.
- Tick width: exactly one clkglobal cycle, never stretched by pix_en.
- Line: 800 pix_en pulses, i.e. 1600 clkglobal cycles at the nominal pix_en rate. Frame: 525 lines, i.e. 840000 clkglobal cycles.
- hsync asserted for 96 consecutive pix_en pulses per line. vsync asserted for 2 full lines (1600 pix_en).
- Simultaneous h and v wrap at (799,524): both counters go to 0 on the same edge, and line_tick and frame_tick assert together.
- No combinational path from pix_en to any output.

## Structure
- Package vga_timing_pkg holds:
  - the 640x480@60 constants;
  - H_TOTAL/V_TOTAL localparams;
  - the counter width constant (10);
  - a 2-bit phase enum {ACTIVE, FRONT, SYNC, BACK}.
- Sub-module vga_axis_counter:
  - parameters ACTIVE/FP/SYNC/BP; inputs en, clkglobal, reset;
  - outputs cnt_next, phase_next, wrap.
  - Instantiated twice: horizontal with en=pix_en; vertical with en=pix_en & h_wrap.
- The top level adds the output registers and tick generation.

## Test plan
- Reset asserted mid-line (h=300, v=100), then released with pix_en toggling -> immediately outputs pixel_x=799, pixel_y=524, video_on=0, hsync=vsync=1; first pix_en gives (0,0), video_on=1, line_tick=frame_tick=1 for one cycle.
- Free-run one line -> video_on high for pixel_x 0..639; hsync low exactly for pixel_x 656..751; line_tick once, at pixel_x=0.
- Free-run one full frame -> vsync low exactly on lines 490..491; video_on=0 on lines 480..524; frame_tick spacing 840000 clkglobal cycles.
- pix_en held low for 37 cycles at (700,10) -> all outputs frozen, ticks 0; count resumes at (701,10).
- Wrap at (799,524) -> next pix_en yields (0,0), with line_tick and frame_tick asserted on the same cycle.
- SYNC_POL=1 build -> hsync/vsync high only during SYNC phases, low at reset.
